permuter_block_arbiter: RTL and testbench

- Sequential 2x2 permuter block for the bufferless permutation deflection network.
- Each cycle it takes up to two flits and computes each flit's desired output from its productive vector, using the stage-dependent steering rule.
- Resolves port conflicts by age, with a round-robin tie-break, and deflects the loser to the other port.
- Outputs are registered, with one pipeline stage per permuter block; a saturating deflection counter feeds router statistics.

---
 rtl/permuter_block_arbiter_pkg.sv | 18 +
 rtl/permuter_desire_decode.sv | 37 +++
 rtl/permuter_block_arbiter.sv | 150 +++++++++++++++
 tb/tb_permuter_block_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/permuter_block_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : permuter_block_arbiter_pkg
// Brief   : Shared constants for the 2x2 deflection permuter block.
// Revision: 1.0 - initial release
// ============================================================================
package permuter_block_arbiter_pkg;

  localparam int PROD_VECTOR_SIZE = 5;
  localparam int DEF_PV_W         = PROD_VECTOR_SIZE - 1;
  localparam int DEF_AGE_W        = 8;
  localparam int DEF_DATA_W       = 64;

  localparam logic PORT_0 = 1'b0;
  localparam logic PORT_1 = 1'b1;

endpackage : permuter_block_arbiter_pkg
`default_nettype wire

// File: rtl/permuter_desire_decode.sv
`default_nettype none
// ============================================================================
// Module  : permuter_desire_decode
// Brief   : Maps a productive vector to a preferred output port per stage.
// Revision: 1.0 - initial release
// ============================================================================
module permuter_desire_decode
  import permuter_block_arbiter_pkg::*;
#(
  parameter int PV_W = DEF_PV_W
) (
  input  logic [PV_W-1:0] pv_i,
  input  logic            stage_i,
  output logic            pref_valid_o,
  output logic            desire_o
);

  logic want_hi;
  logic want_lo;

  // Stage 1 pairs the productive directions differently from stage 0.
  always_comb begin
    want_hi      = stage_i ? (pv_i[3] | pv_i[1]) : (pv_i[0] | pv_i[1]);
    want_lo      = stage_i ? (pv_i[2] | pv_i[0]) : (pv_i[2] | pv_i[3]);
    pref_valid_o = 1'b0;
    desire_o     = PORT_0;
    if (want_hi) begin
      pref_valid_o = 1'b1;
      desire_o     = PORT_1;
    end else if (want_lo) begin
      pref_valid_o = 1'b1;
      desire_o     = PORT_0;
    end
  end

endmodule : permuter_desire_decode
`default_nettype wire

// File: rtl/permuter_block_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : permuter_block_arbiter
// Brief   : Registered 2x2 permuter with age/round-robin arbitration.
// Revision: 1.0 - initial release
// ============================================================================
module permuter_block_arbiter
  import permuter_block_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PV_W   = DEF_PV_W,
  parameter int AGE_W  = DEF_AGE_W,
  parameter int STAGE  = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid0,
  input  logic              in_valid1,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [PV_W-1:0]   in_pv0,
  input  logic [PV_W-1:0]   in_pv1,
  input  logic [AGE_W-1:0]  in_age0,
  input  logic [AGE_W-1:0]  in_age1,
  input  logic              clr_cnt,
  output logic              out_valid0,
  output logic              out_valid1,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [PV_W-1:0]   out_pv0,
  output logic [PV_W-1:0]   out_pv1,
  output logic [AGE_W-1:0]  out_age0,
  output logic [AGE_W-1:0]  out_age1,
  output logic              swap,
  output logic [CNT_W-1:0]  deflect_cnt
);

  localparam logic STAGE_BIT = (STAGE != 0);

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + AGE_W'(1);
  endfunction

  logic pref0, pref1, desire0, desire1;

  permuter_desire_decode #(.PV_W(PV_W)) u_dec0 (
    .pv_i        (in_pv0),
    .stage_i     (STAGE_BIT),
    .pref_valid_o(pref0),
    .desire_o    (desire0)
  );

  permuter_desire_decode #(.PV_W(PV_W)) u_dec1 (
    .pv_i        (in_pv1),
    .stage_i     (STAGE_BIT),
    .pref_valid_o(pref1),
    .desire_o    (desire1)
  );

  logic              conflict, age_tie, win1;
  logic              swap_d, rr_d;
  logic              valid0_d, valid1_d;
  logic [DATA_W-1:0] data0_d, data1_d;
  logic [PV_W-1:0]   pv0_d, pv1_d;
  logic [AGE_W-1:0]  age0_d, age1_d;
  logic [CNT_W-1:0]  cnt_d;

  logic              swap_q, rr_q;
  logic              valid0_q, valid1_q;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic [PV_W-1:0]   pv0_q, pv1_q;
  logic [AGE_W-1:0]  age0_q, age1_q;
  logic [CNT_W-1:0]  cnt_q;

  always_comb begin
    conflict = in_valid0 & in_valid1 & pref0 & pref1 & (desire0 == desire1);
    age_tie  = (in_age0 == in_age1);
    win1     = (in_age1 > in_age0) | (age_tie & rr_q);

    // A flit on input1 that wants port 0 implies a swap, hence the inversion.
    swap_d = PORT_0;
    if (conflict) begin
      swap_d = win1 ? ~desire1 : desire0;
    end else if (in_valid0 & pref0) begin
      swap_d = desire0;
    end else if (in_valid1 & pref1) begin
      swap_d = ~desire1;
    end

    valid0_d = swap_d ? in_valid1 : in_valid0;
    valid1_d = swap_d ? in_valid0 : in_valid1;
    data0_d  = valid0_d ? (swap_d ? in_data1 : in_data0) : '0;
    data1_d  = valid1_d ? (swap_d ? in_data0 : in_data1) : '0;
    pv0_d    = valid0_d ? (swap_d ? in_pv1 : in_pv0) : '0;
    pv1_d    = valid1_d ? (swap_d ? in_pv0 : in_pv1) : '0;
    age0_d   = valid0_d ? age_inc(swap_d ? in_age1 : in_age0) : '0;
    age1_d   = valid1_d ? age_inc(swap_d ? in_age0 : in_age1) : '0;

    rr_d = rr_q ^ (conflict & age_tie);

    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (conflict && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swap_q   <= 1'b0;
      rr_q     <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      pv0_q    <= '0;
      pv1_q    <= '0;
      age0_q   <= '0;
      age1_q   <= '0;
      cnt_q    <= '0;
    end else begin
      swap_q   <= swap_d;
      rr_q     <= rr_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      pv0_q    <= pv0_d;
      pv1_q    <= pv1_d;
      age0_q   <= age0_d;
      age1_q   <= age1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid0  = valid0_q;
  assign out_valid1  = valid1_q;
  assign out_data0   = data0_q;
  assign out_data1   = data1_q;
  assign out_pv0     = pv0_q;
  assign out_pv1     = pv1_q;
  assign out_age0    = age0_q;
  assign out_age1    = age1_q;
  assign swap        = swap_q;
  assign deflect_cnt = cnt_q;

endmodule : permuter_block_arbiter
`default_nettype wire

// File: tb/tb_permuter_block_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_permuter_block_arbiter
// Brief   : Self-checking bench for two permuter instances (stage 0 and 1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_permuter_block_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv0, iv1, clr;
  logic [63:0] id0, id1;
  logic [3:0]  ipv0, ipv1;
  logic [7:0]  ia0, ia1;

  logic        ov   [2][2];
  logic [63:0] od   [2][2];
  logic [3:0]  opv  [2][2];
  logic [7:0]  oage [2][2];
  logic        osw  [2];
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  permuter_block_arbiter #(.STAGE(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset),
    .in_valid0(iv0), .in_valid1(iv1), .in_data0(id0), .in_data1(id1),
    .in_pv0(ipv0), .in_pv1(ipv1), .in_age0(ia0), .in_age1(ia1), .clr_cnt(clr),
    .out_valid0(ov[0][0]), .out_valid1(ov[0][1]), .out_data0(od[0][0]), .out_data1(od[0][1]),
    .out_pv0(opv[0][0]), .out_pv1(opv[0][1]), .out_age0(oage[0][0]), .out_age1(oage[0][1]),
    .swap(osw[0]), .deflect_cnt(cnt0)
  );

  permuter_block_arbiter #(.STAGE(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_valid0(iv0), .in_valid1(iv1), .in_data0(id0), .in_data1(id1),
    .in_pv0(ipv0), .in_pv1(ipv1), .in_age0(ia0), .in_age1(ia1), .clr_cnt(clr),
    .out_valid0(ov[1][0]), .out_valid1(ov[1][1]), .out_data0(od[1][0]), .out_data1(od[1][1]),
    .out_pv0(opv[1][0]), .out_pv1(opv[1][1]), .out_age0(oage[1][0]), .out_age1(oage[1][1]),
    .swap(osw[1]), .deflect_cnt(cnt1)
  );

  // ---------------- behavioural reference model ----------------
  int e_v [2][2], e_d [2][2], e_pv [2][2], e_age [2][2];
  longint e_data [2][2];
  int e_sw [2], e_cnt [2], rr [2];

  function automatic int desire_of(int st, logic [3:0] pv);
    if (st == 0) begin
      if (pv[0] | pv[1]) return 1;
      if (pv[2] | pv[3]) return 0;
    end else begin
      if (pv[3] | pv[1]) return 1;
      if (pv[2] | pv[0]) return 0;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        e_v[k][p] = 0; e_data[k][p] = 0; e_pv[k][p] = 0; e_age[k][p] = 0;
      end
      e_sw[k] = 0; e_cnt[k] = 0; rr[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    int d0, d1, p0, p1, win, cmax;
    bit conflict;
    cmax = (k == 0) ? 15 : 65535;
    d0 = iv0 ? desire_of(k, ipv0) : -1;
    d1 = iv1 ? desire_of(k, ipv1) : -1;
    conflict = 0;
    p0 = 0; p1 = 1;
    if (iv0 && iv1) begin
      if (d0 >= 0 && d1 >= 0 && d0 == d1) begin
        conflict = 1;
        if (ia0 > ia1) win = 0;
        else if (ia1 > ia0) win = 1;
        else begin win = rr[k]; rr[k] = 1 - rr[k]; end
        if (win == 0) begin p0 = d0; p1 = 1 - d0; end
        else begin p1 = d1; p0 = 1 - d1; end
      end else if (d0 >= 0) begin p0 = d0; p1 = 1 - d0; end
      else if (d1 >= 0) begin p1 = d1; p0 = 1 - d1; end
    end else if (iv0) begin
      p0 = (d0 >= 0) ? d0 : 0;
    end else if (iv1) begin
      p1 = (d1 >= 0) ? d1 : 1;
    end
    e_sw[k] = iv0 ? (p0 == 1) : (iv1 ? (p1 == 0) : 0);
    for (int p = 0; p < 2; p++) begin
      e_v[k][p] = 0; e_data[k][p] = 0; e_pv[k][p] = 0; e_age[k][p] = 0;
    end
    if (iv0) begin
      e_v[k][p0] = 1; e_data[k][p0] = id0; e_pv[k][p0] = ipv0;
      e_age[k][p0] = (ia0 == 255) ? 255 : ia0 + 1;
    end
    if (iv1) begin
      e_v[k][p1] = 1; e_data[k][p1] = id1; e_pv[k][p1] = ipv1;
      e_age[k][p1] = (ia1 == 255) ? 255 : ia1 + 1;
    end
    if (clr) e_cnt[k] = 0;
    else if (conflict && e_cnt[k] < cmax) e_cnt[k] = e_cnt[k] + 1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  // ---------------- checking ----------------
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          check($sformatf("dut%0d valid%0d", k, p), ov[k][p], e_v[k][p]);
          check($sformatf("dut%0d data%0d", k, p), od[k][p], e_data[k][p]);
          check($sformatf("dut%0d pv%0d", k, p), opv[k][p], e_pv[k][p]);
          check($sformatf("dut%0d age%0d", k, p), oage[k][p], e_age[k][p]);
        end
        check($sformatf("dut%0d swap", k), osw[k], e_sw[k]);
      end
      check("dut0 cnt", cnt0, e_cnt[0]);
      check("dut1 cnt", cnt1, e_cnt[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit v0, longint d0, logic [3:0] pv0, int a0,
                       bit v1, longint d1, logic [3:0] pv1, int a1, bit c);
    iv0 = v0; id0 = d0; ipv0 = pv0; ia0 = a0[7:0];
    iv1 = v1; id1 = d1; ipv1 = pv1; ia1 = a1[7:0];
    clr = c;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset valid0", ov[0][0], 0);
    check("reset swap", osw[0], 0);
    check("reset cnt", cnt0, 0);
    @(negedge clk);
    reset = 1'b0;

    // single flit steered to port 1
    drive(1, 'hA, 4'b0001, 5, 0, 0, 0, 0, 0);
    step();
    check("t1 valid1", ov[0][1], 1);
    check("t1 data1", od[0][1], 'hA);
    check("t1 age1", oage[0][1], 6);
    check("t1 valid0", ov[0][0], 0);
    check("t1 swap", osw[0], 1);
    check("t1 cnt", cnt0, 0);

    // distinct desires
    drive(1, 'h11, 4'b0001, 3, 1, 'h22, 4'b0100, 9, 0);
    step();
    check("t2 data1", od[0][1], 'h11);
    check("t2 age1", oage[0][1], 4);
    check("t2 data0", od[0][0], 'h22);
    check("t2 age0", oage[0][0], 10);
    check("t2 swap", osw[0], 1);

    // stage 1 age-based conflict
    do_reset();
    drive(1, 'h33, 4'b1000, 2, 1, 'h44, 4'b0010, 7, 0);
    step();
    check("t3 data1", od[1][1], 'h44);
    check("t3 data0", od[1][0], 'h33);
    check("t3 swap", osw[1], 0);
    check("t3 cnt", cnt1, 1);
    check("t3 model cnt", e_cnt[1], 1);

    // equal-age round robin
    do_reset();
    drive(1, 'h55, 4'b0001, 4, 1, 'h66, 4'b0001, 4, 0);
    step();
    check("t4a swap", osw[0], 1);
    check("t4a data1", od[0][1], 'h55);
    check("t4a data0", od[0][0], 'h66);
    step();
    check("t4b swap", osw[0], 0);
    check("t4b data1", od[0][1], 'h66);
    check("t4b cnt", cnt0, 2);
    check("t4b model cnt", e_cnt[0], 2);

    // saturating age and no preference
    drive(1, 'h77, 4'b0000, 255, 0, 0, 0, 0, 0);
    step();
    check("t5 valid0", ov[0][0], 1);
    check("t5 age0", oage[0][0], 255);
    check("t5 swap", osw[0], 0);
    check("t5 data1", od[0][1], 0);
    drive(1, 'h1, 4'b0000, 1, 1, 'h2, 4'b0000, 2, 0);
    step();
    check("t5b swap", osw[0], 0);
    check("t5b data1", od[0][1], 'h2);

    // clear beats increment, then saturate
    drive(1, 'h8, 4'b0001, 3, 1, 'h9, 4'b0001, 3, 1);
    step();
    check("t6 clr cnt", cnt0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, i, 4'b0001, i % 3, 1, i + 100, 4'b0010, (i + 1) % 3, 0);
      step();
    end
    check("t6 sat cnt", cnt0, 15);

    // asynchronous reset mid-stream
    drive(1, 'hBEEF, 4'b0001, 1, 1, 'hCAFE, 4'b0100, 1, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async valid0", ov[0][0], 0);
    check("async valid1", ov[0][1], 0);
    check("async data1", od[0][1], 0);
    check("async swap", osw[0], 0);
    check("async cnt0", cnt0, 0);
    check("async cnt1", cnt1, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 'hD, 4'b0100, 0, 0, 0, 0, 0, 0);
    step();
    check("post-reset data0", od[0][0], 'hD);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 3),
            $urandom_range(0, 31) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_permuter_block_arbiter
`default_nettype wire
